uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo.sv | 53 +++++
 rtl/uart_tx_buffered.sv | 154 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  localparam int unsigned DefWidth         = 8;
  localparam int unsigned DefDepth         = 4;
  localparam int unsigned DefPrescaleWidth = 6;
  localparam int unsigned MaxWidth         = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Callers zero-extend narrower words, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [MaxWidth-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored.
module uart_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full is judged on occupancy before the edge, so a simultaneous pop never frees a slot.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter with a TX FIFO; frames run back-to-back while words are queued.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH          = DefWidth,
  parameter int unsigned DEPTH          = DefDepth,
  parameter int unsigned PRESCALE_WIDTH = DefPrescaleWidth
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [WIDTH-1:0]          P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy,
  output logic                      FULL,
  output logic                      OVERFLOW
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  tx_state_e                 state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d, bit_len;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [WIDTH-1:0]          data_q, data_d;
  logic                      par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic                      tx_q, tx_d;
  logic                      pop, bit_done;
  logic [WIDTH-1:0]          fifo_rdata;
  logic                      fifo_full, fifo_empty;
  logic [CntW-1:0]           fifo_count;

  uart_fifo #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (DATA_VALID),
    .wdata_i (P_DATA),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bit_len  = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
  assign bit_done = (cnt_q == bit_len - 1'b1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    pop       = 1'b0;
    tx_d      = 1'b1;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        pop   = ~fifo_empty;
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          cnt_d   = '0;
        end
      end
      StStop: begin
        // idx_q doubles as the stop-bit index here.
        if (bit_done) begin
          cnt_d = '0;
          if (stop2_q && idx_q == '0) begin
            idx_d = IdxW'(1);
          end else begin
            idx_d   = '0;
            state_d = StIdle;
            pop     = ~fifo_empty;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      state_d   = StStart;
      data_d    = fifo_rdata;
      par_en_d  = PAR_EN;
      par_bit_d = parity_bit(MaxWidth'(fifo_rdata), PAR_TYP);
      stop2_d   = STOP2;
    end

    // The line is registered, so it is driven from the next-state view.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_d[idx_d];
      StParity: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
    end
  end

  assign TX_OUT   = tx_q;
  assign Busy     = (state_q != StIdle) || (fifo_count != '0);
  assign FULL     = fifo_full;
  assign OVERFLOW = DATA_VALID & fifo_full;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised and directed bench for uart_tx_buffered against a queue-based line model.
module tb_uart_tx_buffered;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 6;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] P_DATA = '0;
  logic             DATA_VALID = 1'b0;
  logic             PAR_EN = 1'b0;
  logic             PAR_TYP = 1'b0;
  logic             STOP2 = 1'b0;
  logic [PW-1:0]    Prescale = PW'(4);
  logic             TX_OUT, Busy, FULL, OVERFLOW;

  int checks = 0;
  int errors = 0;
  logic wave [0:255];

  always #5 CLK = ~CLK;

  uart_tx_buffered #(
    .WIDTH          (WIDTH),
    .DEPTH          (DEPTH),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .FULL       (FULL),
    .OVERFLOW   (OVERFLOW)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queued words, plus the per-cycle line levels of the frame in flight.
  logic [WIDTH-1:0] m_fifo [$];
  logic             m_line [$];
  logic             m_tx = 1'b1;
  bit               m_inframe = 1'b0;

  always @(posedge CLK or negedge RST) begin : model
    logic [WIDTH-1:0] w;
    logic             lv [$];
    int               pre;
    bit               full_b;
    if (!RST) begin
      m_fifo.delete();
      m_line.delete();
      m_tx      = 1'b1;
      m_inframe = 1'b0;
    end else begin
      full_b = (m_fifo.size() == DEPTH);
      if (m_line.size() == 0 && m_fifo.size() > 0) begin
        w   = m_fifo.pop_front();
        pre = (Prescale == 0) ? 1 : int'(Prescale);
        lv.delete();
        lv.push_back(1'b0);
        for (int i = 0; i < WIDTH; i++) lv.push_back(w[i]);
        if (PAR_EN) lv.push_back((^w) ^ PAR_TYP);
        lv.push_back(1'b1);
        if (STOP2) lv.push_back(1'b1);
        foreach (lv[i]) repeat (pre) m_line.push_back(lv[i]);
      end
      if (DATA_VALID && !full_b) m_fifo.push_back(P_DATA);
      if (m_line.size() > 0) begin
        m_tx      = m_line.pop_front();
        m_inframe = 1'b1;
      end else begin
        m_tx      = 1'b1;
        m_inframe = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin : compare
    if (!RST) begin
      check("rst_tx", TX_OUT, 1'b1);
      check("rst_busy", Busy, 1'b0);
      check("rst_full", FULL, 1'b0);
      check("rst_overflow", OVERFLOW, 1'b0);
    end else begin
      check("tx", TX_OUT, m_tx);
      check("busy", Busy, m_inframe || (m_fifo.size() > 0));
      check("full", FULL, m_fifo.size() == DEPTH);
      check("overflow", OVERFLOW, DATA_VALID && (m_fifo.size() == DEPTH));
    end
  end

  // Called at posedge+1; the write is taken on the next rising edge.
  task automatic write_word(input logic [WIDTH-1:0] w);
    DATA_VALID = 1'b1;
    P_DATA     = w;
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
  endtask

  // lat: cycles from the write edge until the line first goes low; len: frame cycles.
  task automatic capture(output int lat, output int len);
    lat = 0;
    len = 0;
    @(negedge CLK);
    while (TX_OUT !== 1'b0 && lat < 50) begin
      @(negedge CLK);
      lat++;
    end
    while (Busy === 1'b1 && len < 256) begin
      wave[len] = TX_OUT;
      len++;
      @(negedge CLK);
    end
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [9:0] pack10(input int step);
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = wave[i * step];
    return v;
  endfunction

  task automatic drain();
    int n = 0;
    while (Busy === 1'b1 && n < 2000) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check("drain_idle", Busy, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int lat, len, tail;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_tx", TX_OUT, 1'b1);
    check("reset_busy", Busy, 1'b0);

    // 0xA5, prescale 4, no parity, one stop; written on the first edge out of reset.
    RST = 1'b1;
    write_word(8'hA5);
    capture(lat, len);
    check("a5_latency", lat, 1);
    check("a5_len", len, 40);
    check("a5_bits", pack10(4), 10'b1101001010);

    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    write_word(8'hA5);
    capture(lat, len);
    check("par_even_len", len, 44);
    check("par_even_bit", wave[36], 1'b0);
    PAR_TYP = 1'b1;
    write_word(8'hA5);
    capture(lat, len);
    check("par_odd_len", len, 44);
    check("par_odd_bit", wave[36], 1'b1);

    PAR_EN   = 1'b0;
    STOP2    = 1'b1;
    Prescale = PW'(2);
    write_word(8'h3C);
    capture(lat, len);
    check("stop2_len", len, 22);
    tail = 0;
    for (int i = len - 1; i >= 0 && wave[i] == 1'b1; i--) tail++;
    check("stop2_tail", tail, 4);

    STOP2    = 1'b0;
    Prescale = '0;
    write_word(8'h5A);
    capture(lat, len);
    check("pre0_len", len, 10);
    check("pre0_bits", pack10(1), 10'b1010110100);

    // Six writes on consecutive cycles: the sixth is dropped.
    Prescale = PW'(2);
    for (int i = 0; i < 6; i++) begin
      DATA_VALID = 1'b1;
      P_DATA     = WIDTH'($urandom);
      if (i == 5) begin
        @(negedge CLK);
        check("burst_overflow", OVERFLOW, 1'b1);
        check("burst_full", FULL, 1'b1);
      end
      @(posedge CLK);
      #1;
    end
    DATA_VALID = 1'b0;
    drain();

    // Reset in the middle of a data bit with a second word queued.
    Prescale = PW'(4);
    write_word(8'h00);
    write_word(8'h33);
    repeat (8) @(posedge CLK);
    #1;
    check("pre_rst_tx", TX_OUT, 1'b0);
    RST = 1'b0;
    #1;
    check("midrst_tx", TX_OUT, 1'b1);
    check("midrst_busy", Busy, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    write_word(8'hA5);
    capture(lat, len);
    check("post_rst_latency", lat, 1);
    check("post_rst_len", len, 40);
    check("post_rst_bits", pack10(4), 10'b1101001010);

    // Random traffic; frame config varies every cycle, prescale only while idle.
    for (int b = 0; b < 4; b++) begin
      Prescale = PW'(b);
      for (int c = 0; c < 200; c++) begin
        DATA_VALID = ($urandom_range(0, 3) == 0);
        P_DATA     = WIDTH'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        STOP2      = 1'($urandom);
        @(posedge CLK);
        #1;
      end
      DATA_VALID = 1'b0;
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
